instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width in bits of the byte program-counter and memory address.
REQ-002 SHALL have parameter WORD_SIZE, default 32, width in bits of one instruction word.
REQ-003 SHALL have parameter RESET_ADDR, default 0, PC value loaded on reset; bits [1:0] are zero.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port redirect_valid  input  1  high for one cycle to restart fetch at redirect_addr.
REQ-007 SHALL have port redirect_addr  input  ADDR_WIDTH  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-008 SHALL have port imem_rd_en  output  1  read request to the synchronous instruction memory.
REQ-009 SHALL have port imem_addr  output  ADDR_WIDTH  byte address of the read request.
REQ-010 SHALL have port imem_data  input  WORD_SIZE  read data, valid in the cycle after imem_rd_en.
REQ-011 SHALL have port instr_valid  output  1  instr and instr_pc hold a fetched instruction.
REQ-012 SHALL have port instr_ready  input  1  decode accepts the instruction this cycle.
REQ-013 SHALL have port instr  output  WORD_SIZE  fetched instruction word.
REQ-014 SHALL have port instr_pc  output  ADDR_WIDTH  byte address instr was fetched from.
REQ-015 SHALL have port fetch_count  output  32  count of instructions accepted by decode.

Function
REQ-016 SHALL keep a 2-entry FIFO of {instr, instr_pc} and a 1-bit in-flight flag for the outstanding read.
REQ-017 SHALL drive instr_valid high exactly when the FIFO is non-empty, with instr/instr_pc showing the FIFO head.
REQ-018 SHALL pop the head in any cycle where instr_valid and instr_ready are both high; instr_ready while instr_valid is low has no effect.
REQ-019 SHALL hold instr and instr_pc stable while instr_valid is high and instr_ready is low.
REQ-020 SHALL issue a read (imem_rd_en=1, imem_addr=PC, PC<=PC+4) when count + in-flight - pop < 2 and redirect_valid is low.
REQ-021 SHALL write imem_data together with its issue address into the FIFO in the cycle after issue, unless that read was flushed.
REQ-022 SHALL sustain one instruction per cycle while instr_ready stays high, and never overflow the FIFO under any instr_ready pattern.
REQ-023 SHALL wrap PC modulo 2^ADDR_WIDTH; from all-ones-minus-3 the next fetch address is 0.
REQ-024 SHALL, on redirect_valid, empty the FIFO, discard the in-flight response, load PC with {redirect_addr[ADDR_WIDTH-1:2],2'b00}, and issue no read that cycle.
REQ-025 SHALL give redirect priority over a simultaneous pop, issue, or memory response.
REQ-026 SHALL issue its first read in the first cycle after reset deasserts, with instr_valid rising two cycles later.
REQ-027 SHALL issue from the redirect target one cycle after redirect_valid, with instr_valid rising three cycles after redirect_valid.

Reset
REQ-028 SHALL, while reset is high, asynchronously set PC=RESET_ADDR, FIFO empty, in-flight=0 and fetch_count=0.
REQ-029 SHALL, while reset is high, drive imem_rd_en=0, imem_addr=RESET_ADDR, instr_valid=0, instr=0 and instr_pc=0.
REQ-030 SHALL, when reset asserts mid-operation, discard any outstanding read so that its response never enters the FIFO.

Configuration
REQ-031 SHALL, with macro IFETCH_PERF_CNT_EN defined, increment fetch_count by 1 on every pop and saturate it at 32'hFFFFFFFF.
REQ-032 SHALL, with IFETCH_PERF_CNT_EN undefined, tie fetch_count to 0 and include no counter logic.

Verification
REQ-033 SHALL check: reset release with RESET_ADDR=0, instr_ready=1 and mem[i]=i -> reads at 0,4,8; instr_valid rises 2 cycles after release; instr_pc 0,4,8 with instr 0,1,2 on consecutive cycles.
REQ-034 SHALL check: instr_ready=0 for 5 cycles mid-stream -> imem_rd_en stops after the FIFO holds 2 entries; instr/instr_pc hold stable; on release the stream resumes with no PC skipped or duplicated.
REQ-035 SHALL check: redirect_valid with redirect_addr=8'h43 while 1 read is in flight and 2 entries are queued -> instr_valid low the next cycle; read issued at 8'h40; first instr_pc after the redirect is 8'h40; the stale response is dropped.
REQ-036 SHALL check: PC reaching 8'hFC with ADDR_WIDTH=8 -> next imem_addr is 8'h00 and instr_pc goes 8'hFC then 8'h00.
REQ-037 SHALL check: reset asserted on the cycle after an issue -> outputs at reset values immediately; after release the first instr_pc is RESET_ADDR.
REQ-038 SHALL check: with IFETCH_PERF_CNT_EN defined, 10 accepted instructions -> fetch_count=10; with the macro undefined -> fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: redirect input, instruction-memory read port, decode handshake
// and the accepted-instruction counter.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_SIZE  = 32
);
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  imem_rd_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [WORD_SIZE-1:0]  imem_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_SIZE-1:0]  instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [31:0]           fetch_count;

    modport master (
        input  redirect_valid, redirect_addr, imem_data, instr_ready,
        output imem_rd_en, imem_addr, instr_valid, instr, instr_pc, fetch_count
    );

    modport slave (
        output redirect_valid, redirect_addr, imem_data, instr_ready,
        input  imem_rd_en, imem_addr, instr_valid, instr, instr_pc, fetch_count
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential PC, one-cycle synchronous imem, 2-entry output FIFO.
// Define IFETCH_PERF_CNT_EN to build the saturating accepted-instruction counter.
module instruction_fetch #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    WORD_SIZE  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input logic               clk,
    input logic               reset,
    instruction_fetch_if.master bus
);
    logic [ADDR_WIDTH-1:0]            pc;
    logic [ADDR_WIDTH-1:0]            infl_pc;
    logic                             infl;
    logic [1:0]                       count;
    logic [1:0][WORD_SIZE-1:0]        q_instr;
    logic [1:0][ADDR_WIDTH-1:0]       q_pc;
    logic                             pop;
    logic                             push;
    logic                             issue;
    logic [2:0]                       occ;
    logic                             unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.redirect_addr[1:0];

    assign pop  = (count != 2'd0) && bus.instr_ready;
    assign push = infl;
    assign occ  = {1'b0, count} + {2'b00, infl};
    // Issue only if the response is guaranteed a free slot next cycle.
    assign issue = !reset && !bus.redirect_valid && (occ < (3'd2 + {2'b00, pop}));

    assign bus.imem_rd_en  = issue;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr       = q_instr[0];
    assign bus.instr_pc    = q_pc[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_ADDR;
            infl_pc <= '0;
            infl    <= 1'b0;
            count   <= 2'd0;
            q_instr <= '0;
            q_pc    <= '0;
        end else if (bus.redirect_valid) begin
            pc    <= {bus.redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            infl  <= 1'b0;
            count <= 2'd0;
        end else begin
            infl <= issue;
            if (issue) begin
                pc      <= pc + ADDR_WIDTH'(4);
                infl_pc <= pc;
            end
            // Shift FIFO: entry 0 is always the head.
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q_instr[0] <= bus.imem_data;
                        q_pc[0]    <= infl_pc;
                    end else begin
                        q_instr[1] <= bus.imem_data;
                        q_pc[1]    <= infl_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q_instr[0] <= q_instr[1];
                    q_pc[0]    <= q_pc[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_instr[0] <= bus.imem_data;
                        q_pc[0]    <= infl_pc;
                    end else begin
                        q_instr[0] <= q_instr[1];
                        q_pc[0]    <= q_pc[1];
                        q_instr[1] <= bus.imem_data;
                        q_pc[1]    <= infl_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_cnt;

    // A pop overridden by a redirect is not an accepted instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            perf_cnt <= '0;
        else if (pop && !bus.redirect_valid && (perf_cnt != 32'hFFFF_FFFF))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign bus.fetch_count = perf_cnt;
`else
    assign bus.fetch_count = '0;
`endif
endmodule
